joystick_axes: RTL and testbench

- Parametrised multi-axis joystick position integrator. It is the successor of the fixed 2-axis X/Y joystick datapath.
- It takes the byte stream from the UART receiver and demultiplexes it round-robin into N_AXES channels. Each channel gets a deadzone and a rate-proportional stepper, producing a saturating or wrapping position.
- It also toggles a menu state bit on button presses.
- Sits between uart_rx (upstream) and the 7-segment/display logic (downstream).

---
 rtl/joystick_axes.sv | 166 ++++++++++++++++
 tb/tb_joystick_axes.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_axes.sv
// joystick_axes: multi-axis joystick position integrator.
// Bytes from the UART receiver are dealt round-robin to N_AXES channels.
// Each channel has a deadzone decoder and a rate-proportional stepper that
// moves a saturating (or wrapping) position counter. A synchronised push
// button toggles a menu state bit.
//
// Input handshake: valid_i is a single-cycle strobe with no back-pressure.
// Every rising clk_i edge that sees valid_i high consumes data_i into the
// channel addressed by sel_o. The block never stalls the producer.
module joystick_axes #(
    parameter int         N_AXES  = 2,
    parameter int         POS_W   = 8,
    parameter int         TICK_W  = 20,
    parameter logic [7:0] DEAD_LO = 8'h7C,
    parameter logic [7:0] DEAD_HI = 8'h83,
    parameter bit         WRAP    = 1'b0,
    localparam int        SEL_W   = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              data_i,
    input  logic                    valid_i,
    input  logic                    btn_i,
    output logic [SEL_W-1:0]        sel_o,
    output logic [8*N_AXES-1:0]     axis_o,
    output logic [POS_W*N_AXES-1:0] pos_o,
    output logic [N_AXES-1:0]       moving_o,
    output logic                    tick_o,
    output logic                    state_o
);

    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_AXES - 1);
    localparam logic [POS_W-1:0]  POS_MAX  = '1;
    // Prescaler value one below all-ones: registering the compare against
    // this value makes tick_o high exactly while the prescaler is all-ones.
    localparam logic [TICK_W-1:0] PRE_LAST = ~(TICK_W'(1));

    logic [7:0]        axis_q [N_AXES];
    logic [POS_W-1:0]  pos_q  [N_AXES];
    logic [6:0]        cnt_q  [N_AXES];
    logic [6:0]        period [N_AXES];
    logic [N_AXES-1:0] up_dir;
    logic [N_AXES-1:0] dn_dir;
    logic [TICK_W-1:0] presc_q;
    logic              btn_sync1;
    logic              btn_sync2;
    logic              btn_prev;
    logic              btn_rise;

    // Round-robin channel pointer, advanced by each accepted byte.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sel_o <= '0;
        end else if (valid_i) begin
            sel_o <= (sel_o == SEL_LAST) ? '0 : sel_o + SEL_W'(1);
        end
    end

    // Capture the strobed byte into the channel the pointer addresses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < N_AXES; k++) begin
                axis_q[k] <= 8'h80;
            end
        end else if (valid_i) begin
            for (int k = 0; k < N_AXES; k++) begin
                if (sel_o == SEL_W'(k)) begin
                    axis_q[k] <= data_i;
                end
            end
        end
    end

    // Free-running step prescaler with a registered one-cycle tick.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            presc_q <= '0;
            tick_o  <= 1'b0;
        end else begin
            presc_q <= presc_q + TICK_W'(1);
            tick_o  <= (presc_q == PRE_LAST);
        end
    end

    // Deadzone decode: direction and step period from the registered sample.
    // The further the stick is from centre, the shorter the period.
    always_comb begin
        for (int k = 0; k < N_AXES; k++) begin
            up_dir[k] = 1'b0;
            dn_dir[k] = 1'b0;
            period[k] = 7'd0;
            if (axis_q[k] < DEAD_LO) begin
                dn_dir[k] = 1'b1;
                period[k] = axis_q[k][6:0];
            end else if (axis_q[k] > DEAD_HI) begin
                up_dir[k] = 1'b1;
                period[k] = 7'd127 - axis_q[k][6:0];
            end
        end
    end

    // Per-axis stepper and position counter, advanced only on a tick.
    // The >= compare lets a freshly shortened period step on the next tick
    // instead of waiting for the 7-bit counter to wrap.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < N_AXES; k++) begin
                cnt_q[k] <= 7'd0;
                pos_q[k] <= '0;
            end
        end else if (tick_o) begin
            for (int k = 0; k < N_AXES; k++) begin
                if (!(up_dir[k] || dn_dir[k])) begin
                    cnt_q[k] <= 7'd0;
                end else if (cnt_q[k] >= period[k]) begin
                    cnt_q[k] <= 7'd0;
                    if (up_dir[k]) begin
                        if (pos_q[k] == POS_MAX) begin
                            pos_q[k] <= WRAP ? '0 : pos_q[k];
                        end else begin
                            pos_q[k] <= pos_q[k] + POS_W'(1);
                        end
                    end else begin
                        if (pos_q[k] == '0) begin
                            pos_q[k] <= WRAP ? POS_MAX : pos_q[k];
                        end else begin
                            pos_q[k] <= pos_q[k] - POS_W'(1);
                        end
                    end
                end else begin
                    cnt_q[k] <= cnt_q[k] + 7'd1;
                end
            end
        end
    end

    // Button: two-flop synchroniser, edge history, and menu toggle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            btn_sync1 <= 1'b0;
            btn_sync2 <= 1'b0;
            btn_prev  <= 1'b0;
            state_o   <= 1'b0;
        end else begin
            btn_sync1 <= btn_i;
            btn_sync2 <= btn_sync1;
            btn_prev  <= btn_sync2;
            state_o   <= state_o ^ btn_rise;
        end
    end

    assign btn_rise = btn_sync2 & ~btn_prev;

    // Flatten the per-axis registers onto the packed output buses.
    always_comb begin
        axis_o   = '0;
        pos_o    = '0;
        moving_o = '0;
        for (int k = 0; k < N_AXES; k++) begin
            axis_o[8*k +: 8]         = axis_q[k];
            pos_o[POS_W*k +: POS_W]  = pos_q[k];
            moving_o[k]              = up_dir[k] | dn_dir[k];
        end
    end

endmodule

// File: tb/tb_joystick_axes.sv
// Directed bench for joystick_axes: a 2-axis saturating instance (a_*) and a
// 3-axis wrapping instance (b_*), both with a 16-clock step tick.
module tb_joystick_axes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: N_AXES=2, POS_W=8, WRAP=0
    logic        a_rst, a_valid, a_btn;
    logic [7:0]  a_data;
    logic [0:0]  a_sel;
    logic [15:0] a_axis, a_pos;
    logic [1:0]  a_moving;
    logic        a_tick, a_state;

    // Instance B: N_AXES=3, POS_W=8, WRAP=1
    logic        b_rst, b_valid, b_btn;
    logic [7:0]  b_data;
    logic [1:0]  b_sel;
    logic [23:0] b_axis, b_pos;
    logic [2:0]  b_moving;
    logic        b_tick, b_state;

    joystick_axes #(.N_AXES(2), .POS_W(8), .TICK_W(4), .WRAP(1'b0)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .data_i(a_data), .valid_i(a_valid),
        .btn_i(a_btn), .sel_o(a_sel), .axis_o(a_axis), .pos_o(a_pos),
        .moving_o(a_moving), .tick_o(a_tick), .state_o(a_state)
    );

    joystick_axes #(.N_AXES(3), .POS_W(8), .TICK_W(4), .WRAP(1'b1)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .data_i(b_data), .valid_i(b_valid),
        .btn_i(b_btn), .sel_o(b_sel), .axis_o(b_axis), .pos_o(b_pos),
        .moving_o(b_moving), .tick_o(b_tick), .state_o(b_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe, driven and released on falling edges.
    task automatic strobe(input int which, input logic [7:0] d);
        if (which == 0) begin
            a_data = d; a_valid = 1'b1;
        end else begin
            b_data = d; b_valid = 1'b1;
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Wait for n ticks, then cross the edge on which the last one acts.
    task automatic wait_ticks(input int which, input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < n * 16 + 64) begin
            @(negedge clk);
            cyc++;
            if ((which == 0) ? a_tick : b_tick) seen++;
        end
        check("tick_budget", 32'(seen), 32'(n));
        @(negedge clk);
    endtask

    // Strobe into instance A so that the capture edge is also a tick edge.
    task automatic strobe_on_tick_a(input logic [7:0] d);
        int cyc = 0;
        @(negedge clk);
        while (!a_tick && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("tick_align", 32'(a_tick), 32'd1);
        strobe(0, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b0; a_valid = 1'b0; a_btn = 1'b0; a_data = 8'h00;
        b_rst = 1'b0; b_valid = 1'b0; b_btn = 1'b0; b_data = 8'h00;
        repeat (3) @(negedge clk);
        a_rst = 1'b1;

        // Reset state
        check("rst_sel",    32'(a_sel),    32'd0);
        check("rst_axis",   32'(a_axis),   32'h8080);
        check("rst_pos",    32'(a_pos),    32'h0000);
        check("rst_tick",   32'(a_tick),   32'd0);
        check("rst_state",  32'(a_state),  32'd0);
        check("rst_moving", 32'(a_moving), 32'd0);

        // Capture 00 then FF; axis0 down at 0 holds, axis1 up every tick
        strobe(0, 8'h00);
        check("cap0_sel",  32'(a_sel),  32'd1);
        check("cap0_axis", 32'(a_axis), 32'h8000);
        strobe(0, 8'hFF);
        check("cap1_sel",  32'(a_sel),  32'd0);
        check("cap1_axis", 32'(a_axis), 32'hFF00);
        check("cap_moving", 32'(a_moving), 32'd3);
        wait_ticks(0, 5);
        check("step5_pos", 32'(a_pos), 32'h0500);

        // Set the menu bit so the reset check below has something to clear
        a_btn = 1'b1;
        repeat (4) @(negedge clk);
        check("btn_a_set", 32'(a_state), 32'd1);
        a_btn = 1'b0;

        wait_ticks(0, 32);
        check("step37_pos", 32'(a_pos), 32'h2500);

        // Asynchronous reset in the middle of a low clock phase
        #2 a_rst = 1'b0;
        #1;
        check("arst_pos",   32'(a_pos),   32'h0000);
        check("arst_sel",   32'(a_sel),   32'd0);
        check("arst_axis",  32'(a_axis),  32'h8080);
        check("arst_state", 32'(a_state), 32'd0);
        check("arst_tick",  32'(a_tick),  32'd0);
        @(negedge clk);
        a_rst = 1'b1;

        // Period shrink: pos1 to 10, then period 64 for 50 ticks, then FF
        strobe(0, 8'h80);
        strobe(0, 8'hFF);
        wait_ticks(0, 10);
        check("shr_pre_pos", 32'(a_pos), 32'h0A00);
        strobe(0, 8'h80);
        strobe(0, 8'h40);
        wait_ticks(0, 50);
        check("shr_cnt50_pos", 32'(a_pos), 32'h0A00);
        strobe(0, 8'h80);
        strobe(0, 8'hFF);
        wait_ticks(0, 1);
        check("shr_first_step", 32'(a_pos), 32'h0B00);
        wait_ticks(0, 3);
        check("shr_every_tick", 32'(a_pos), 32'h0E00);

        // Strobe coincident with a tick: that tick still uses FF
        strobe(0, 8'h80);
        strobe_on_tick_a(8'h80);
        check("coin_pos",  32'(a_pos),  32'h0F00);
        check("coin_axis", 32'(a_axis), 32'h8080);
        wait_ticks(0, 2);
        check("coin_after_pos", 32'(a_pos), 32'h0F00);

        // Deadzone edges 7C / 83 are idle
        strobe(0, 8'h7C);
        strobe(0, 8'h83);
        check("dz_axis",   32'(a_axis),   32'h837C);
        check("dz_moving", 32'(a_moving), 32'd0);
        wait_ticks(0, 300);
        check("dz_frozen", 32'(a_pos), 32'h0F00);

        // 84 is up with period 123: first step on the 124th tick
        strobe(0, 8'h84);
        check("p123_moving", 32'(a_moving), 32'd1);
        wait_ticks(0, 123);
        check("p123_before", 32'(a_pos), 32'h0F00);
        wait_ticks(0, 1);
        check("p123_step", 32'(a_pos), 32'h0F01);

        // Saturation at the top without wrap
        strobe(0, 8'hFF);
        strobe(0, 8'h80);
        wait_ticks(0, 240);
        check("sat_reach", 32'(a_pos), 32'hFF01);
        wait_ticks(0, 5);
        check("sat_hold", 32'(a_pos), 32'hFF01);

        // Instance B: 3 axes, wrapping positions
        @(negedge clk);
        b_rst = 1'b1;
        check("b_rst_sel",  32'(b_sel),  32'd0);
        check("b_rst_axis", 32'(b_axis), 32'h808080);
        repeat (14) @(negedge clk);
        check("b_tick_lo", 32'(b_tick), 32'd0);
        @(negedge clk);
        check("b_tick_hi", 32'(b_tick), 32'd1);
        @(negedge clk);
        check("b_tick_one", 32'(b_tick), 32'd0);

        strobe(1, 8'h00);
        check("b_sel1", 32'(b_sel), 32'd1);
        strobe(1, 8'h80);
        check("b_sel2", 32'(b_sel), 32'd2);
        strobe(1, 8'h33);
        check("b_sel0", 32'(b_sel), 32'd0);
        check("b_axis3", 32'(b_axis), 32'h338000);
        strobe(1, 8'h00);
        check("b_sel1b", 32'(b_sel), 32'd1);
        check("b_axis4", 32'(b_axis), 32'h338000);
        check("b_moving", 32'(b_moving), 32'd5);
        wait_ticks(1, 1);
        check("b_wrap_down", 32'(b_pos), 32'h0000FF);
        wait_ticks(1, 1);
        check("b_after_wrap", 32'(b_pos), 32'h0000FE);

        // Button: toggle 3 cycles after the rise, once per press
        b_btn = 1'b1;
        @(negedge clk);
        check("btn_c1", 32'(b_state), 32'd0);
        @(negedge clk);
        check("btn_c2", 32'(b_state), 32'd0);
        @(negedge clk);
        check("btn_c3", 32'(b_state), 32'd1);
        repeat (7) @(negedge clk);
        check("btn_held", 32'(b_state), 32'd1);
        b_btn = 1'b0;
        repeat (5) @(negedge clk);
        check("btn_fall", 32'(b_state), 32'd1);
        b_btn = 1'b1;
        repeat (2) @(negedge clk);
        check("btn2_c2", 32'(b_state), 32'd1);
        @(negedge clk);
        check("btn2_c3", 32'(b_state), 32'd0);
        b_btn = 1'b0;
        repeat (5) @(negedge clk);
        check("btn2_rel", 32'(b_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
